// File: rtl/instr_pkg.sv
// Shared definitions for the instruction word: opcodes, field positions, error codes, loader states.
// Latency: none (definitions only).
// Backpressure: not applicable.
package instr_pkg;

  // Opcodes carried in word[31:28]
  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LOAD   = 4'd1;
  localparam logic [3:0] OP_STORE  = 4'd2;
  localparam logic [3:0] OP_BRANCH = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_ADD    = 4'd5;
  localparam logic [3:0] OP_ROTATE = 4'd6;
  localparam logic [3:0] OP_SHIFT  = 4'd7;
  localparam logic [3:0] OP_HALT   = 4'd8;
  localparam logic [3:0] OP_CMP    = 4'd9;

  // Field layout of the 32-bit instruction word
  localparam int INSTR_W   = 32;
  localparam int OPC_LSB   = 28;
  localparam int OPC_W     = 4;
  localparam int CC_LSB    = 24;
  localparam int CC_W      = 4;
  localparam int STYPE_BIT = 27;
  localparam int DTYPE_BIT = 26;
  localparam int SRC_LSB   = 12;
  localparam int SRC_W     = 12;
  localparam int DEST_LSB  = 0;
  localparam int DEST_W    = 12;

  // Status codes reported on err_code
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Opcodes 10..15 are unassigned
  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_CMP;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Packs one field tuple into a 32-bit instruction word and flags unassigned opcodes.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module instr_pack
  import instr_pkg::*;
(
  input  logic [3:0]         opcode,
  input  logic [3:0]         cc,
  input  logic               src_type,
  input  logic               dest_type,
  input  logic [11:0]        src,
  input  logic [11:0]        dest,
  output logic [INSTR_W-1:0] word,
  output logic               illegal
);

  // Field placement by opcode class; fields an opcode does not use stay zero
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    word[OPC_LSB +: OPC_W] = opcode;
    case (opcode)
      OP_BRANCH: begin
        word[CC_LSB +: CC_W]     = cc;
        word[DEST_LSB +: DEST_W] = dest;
      end
      OP_LOAD, OP_STORE, OP_XOR, OP_ADD, OP_CMP: begin
        word[STYPE_BIT]          = src_type;
        word[DTYPE_BIT]          = dest_type;
        word[SRC_LSB +: SRC_W]   = src;
        word[DEST_LSB +: DEST_W] = dest;
      end
      OP_ROTATE, OP_SHIFT: begin
        // src carries the count, passed through untouched; no source type
        word[DTYPE_BIT]          = dest_type;
        word[SRC_LSB +: SRC_W]   = src;
        word[DEST_LSB +: DEST_W] = dest;
      end
      OP_NOP, OP_HALT: begin
        word = {opcode, 28'd0};
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs field tuples and writes them sequentially into program memory from address 0.
// Latency: an accepted tuple appears on mem_we/mem_addr/mem_wdata for exactly the following cycle.
// Backpressure: in_ready is high only in LOAD without start; HALT, illegal opcode or overflow drop it.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [3:0]        in_cc,
  input  logic              in_src_type,
  input  logic              in_dest_type,
  input  logic [11:0]       in_src,
  input  logic [11:0]       in_dest,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W = ADDR_W + 1;
  // Highest writable address, at counter width
  localparam logic [CNT_W-1:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic [31:0]         packed_word;
  logic                packed_illegal;
  logic                accept;

  instr_pack u_pack (
    .opcode    (in_opcode),
    .cc        (in_cc),
    .src_type  (in_src_type),
    .dest_type (in_dest_type),
    .src       (in_src),
    .dest      (in_dest),
    .word      (packed_word),
    .illegal   (packed_illegal)
  );

  // start wins over a tuple presented in the same cycle
  assign in_ready = (state_q == ST_LOAD) && !start;
  assign accept   = in_valid && in_ready;

  // State, counter (also the write pointer) and write-port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state, status and write-port decisions for this cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    if (start) begin
      // Restart from address 0; a write registered last edge still goes out
      state_d    = ST_LOAD;
      cnt_d      = '0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
    end else if (accept) begin
      if (packed_illegal) begin
        state_d    = ST_ERR;
        err_d      = 1'b1;
        err_code_d = ERR_ILLEGAL;
      end else begin
        we_d    = 1'b1;
        addr_d  = cnt_q[ADDR_W-1:0];
        wdata_d = packed_word;
        cnt_d   = cnt_q + CNT_W'(1);
        if (in_opcode == OP_HALT) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (cnt_q == LAST_ADDR) begin
          // Last slot filled by a non-HALT word: stop rather than wrap
          state_d    = ST_ERR;
          err_d      = 1'b1;
          err_code_d = ERR_OVERFLOW;
        end
      end
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign busy       = (state_q == ST_LOAD);
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign word_count = cnt_q;

endmodule
